// File: rtl/blink_rate_ctrl.sv
// Button-driven blink rate selector: debounces BTN, steps RATE on each clean
// press and emits a TICK strobe every (BASE_DIV >> RATE) clocks.
module blink_rate_ctrl #(
    parameter int BASE_DIV        = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       CLK50,
    input  logic       RST,
    input  logic       BTN,
    output logic       TICK,
    output logic [1:0] RATE,
    output logic       PRESS,
    output logic       BTN_LEVEL
);

    localparam int CW = $clog2(BASE_DIV);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic RELEASED = BTN_ACTIVE_LOW;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] db_cnt, db_cnt_nxt;
    logic          press_nxt;
    logic          level_nxt;
    logic          sync1, sync2, synced;
    logic [CW-1:0] div_cnt;
    logic [CW-1:0] term;

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
        end
    end

    // 1 = pressed regardless of board wiring
    assign synced = BTN_ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state  <= state_nxt;
            db_cnt <= db_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        press_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (synced) begin
                    state_nxt  = PRESS_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!synced) begin
                    state_nxt  = IDLE;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = PRESSED;
                    db_cnt_nxt = '0;
                    press_nxt  = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + DW'(1);
                end
            end
            PRESSED: begin
                if (!synced) begin
                    state_nxt  = RELEASE_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            RELEASE_WAIT: begin
                if (synced) begin
                    state_nxt  = PRESSED;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = IDLE;
                    db_cnt_nxt = '0;
                end else begin
                    db_cnt_nxt = db_cnt + DW'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                db_cnt_nxt = '0;
            end
        endcase
    end

    assign level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);

    always_comb begin
        term = CW'(BASE_DIV - 1);
        unique case (RATE)
            2'd0: term = CW'(BASE_DIV - 1);
            2'd1: term = CW'((BASE_DIV >> 1) - 1);
            2'd2: term = CW'((BASE_DIV >> 2) - 1);
            2'd3: term = CW'((BASE_DIV >> 3) - 1);
            default: term = CW'(BASE_DIV - 1);
        endcase
    end

    // A press restarts the period at the new rate and swallows a coincident tick
    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            div_cnt   <= '0;
            TICK      <= 1'b0;
            RATE      <= 2'd0;
            PRESS     <= 1'b0;
            BTN_LEVEL <= 1'b0;
        end else begin
            PRESS     <= press_nxt;
            BTN_LEVEL <= level_nxt;
            if (press_nxt) begin
                RATE    <= RATE + 2'd1;
                div_cnt <= '0;
                TICK    <= 1'b0;
            end else if (div_cnt == term) begin
                div_cnt <= '0;
                TICK    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + CW'(1);
                TICK    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Bench for blink_rate_ctrl: expected PRESS/TICK cycles are queued as stimulus
// is driven and matched against the strobes seen on each falling edge.
module tb_blink_rate_ctrl;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       tick;
    logic [1:0] rate;
    logic       press;
    logic       btn_level;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit tick_en = 1'b0;
    int pq[$];
    int tq[$];
    int last_p  = 0;

    blink_rate_ctrl #(
        .BASE_DIV       (16),
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK50    (clk),
        .RST      (rst),
        .BTN      (btn),
        .TICK     (tick),
        .RATE     (rate),
        .PRESS    (press),
        .BTN_LEVEL(btn_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe scoreboard
    always @(negedge clk) begin
        if (press) begin
            vectors++;
            if (pq.size() != 0 && pq[0] == cyc) begin
                void'(pq.pop_front());
            end else begin
                errors++;
                $display("FAIL press_strobe: PRESS high at cycle %0d, required at %0d",
                         cyc, (pq.size() != 0) ? pq[0] : -1);
                if (pq.size() != 0 && pq[0] < cyc) void'(pq.pop_front());
            end
        end else if (pq.size() != 0 && pq[0] <= cyc) begin
            vectors++;
            errors++;
            $display("FAIL press_missing: PRESS low at cycle %0d, required high at %0d",
                     cyc, pq[0]);
            void'(pq.pop_front());
        end
        if (tick_en) begin
            if (tick) begin
                vectors++;
                if (tq.size() != 0 && tq[0] == cyc) begin
                    void'(tq.pop_front());
                end else begin
                    errors++;
                    $display("FAIL tick_strobe: TICK high at cycle %0d, required at %0d",
                             cyc, (tq.size() != 0) ? tq[0] : -1);
                    if (tq.size() != 0 && tq[0] < cyc) void'(tq.pop_front());
                end
            end else if (tq.size() != 0 && tq[0] <= cyc) begin
                vectors++;
                errors++;
                $display("FAIL tick_missing: TICK low at cycle %0d, required high at %0d",
                         cyc, tq[0]);
                void'(tq.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ticks(input int p, input int per, input int lim);
        for (int k = p + per; k < p + lim; k += per) tq.push_back(k);
    endtask

    task automatic test_reset;
        int r;
        for (int i = 0; i < 3; i++) begin
            step(1);
            vectors++;
            if ({tick, press, rate, btn_level} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs: got tick=%b press=%b rate=%0d level=%b, required all 0",
                         tick, press, rate, btn_level);
            end
        end
        rst = 1'b0;
        r = cyc;
        push_ticks(r, 16, 50);
        tick_en = 1'b1;
        step(50);
        vectors++;
        if (tq.size() != 0) begin
            errors++;
            $display("FAIL reset_ticks: %0d ticks outstanding, required 0", tq.size());
        end
        tick_en = 1'b0;
        tq.delete();
    endtask

    task automatic test_clean_press;
        int t;
        int p;
        t = cyc;
        btn = 1'b0;
        pq.push_back(t + 7);
        step(7);
        p = cyc;
        vectors++;
        if (press !== 1'b1 || rate !== 2'd1 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL clean_press: got press=%b rate=%0d level=%b, required 1/1/1",
                     press, rate, btn_level);
        end
        push_ticks(p, 8, 26);
        tick_en = 1'b1;
        step(13);
        btn = 1'b1;
        step(12);
        vectors++;
        if (tq.size() != 0) begin
            errors++;
            $display("FAIL clean_ticks: %0d ticks outstanding, required 0", tq.size());
        end
        tick_en = 1'b0;
        tq.delete();
        vectors++;
        if (btn_level !== 1'b0 || rate !== 2'd1) begin
            errors++;
            $display("FAIL clean_release: got level=%b rate=%0d, required 0/1",
                     btn_level, rate);
        end
    endtask

    task automatic test_bounce;
        logic [1:0] r0;
        r0 = rate;
        btn = 1'b0;
        step(3);
        btn = 1'b1;
        step(2);
        btn = 1'b0;
        step(2);
        btn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            vectors++;
            if (btn_level !== 1'b0) begin
                errors++;
                $display("FAIL bounce_level: got %b, required 0", btn_level);
            end
        end
        vectors++;
        if (rate !== r0) begin
            errors++;
            $display("FAIL bounce_rate: got %0d, required %0d", rate, r0);
        end
    endtask

    task automatic test_wrap;
        int t;
        int p;
        logic [1:0] er;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        p = cyc;
        for (int i = 0; i < 4; i++) begin
            t = cyc;
            btn = 1'b0;
            pq.push_back(t + 7);
            step(7);
            p = cyc;
            er = 2'(i + 1);
            vectors++;
            if (rate !== er) begin
                errors++;
                $display("FAIL wrap_rate: press %0d got rate %0d, required %0d", i, rate, er);
            end
            push_ticks(p, 16 >> er, (i == 3) ? 34 : 22);
            tick_en = 1'b1;
            step(3);
            btn = 1'b1;
            step(12);
        end
        step(19);
        vectors++;
        if (tq.size() != 0) begin
            errors++;
            $display("FAIL wrap_ticks: %0d ticks outstanding, required 0", tq.size());
        end
        tick_en = 1'b0;
        tq.delete();
        last_p = p;
    endtask

    task automatic test_collision;
        int tgt;
        tgt = last_p;
        while (tgt - 7 < cyc) tgt += 16;
        if (tgt - 7 > cyc) step(tgt - 7 - cyc);
        tick_en = 1'b1;
        btn = 1'b0;
        pq.push_back(tgt);
        step(7);
        vectors++;
        if (tick !== 1'b0 || press !== 1'b1 || rate !== 2'd1) begin
            errors++;
            $display("FAIL collision: got tick=%b press=%b rate=%0d, required 0/1/1",
                     tick, press, rate);
        end
        push_ticks(tgt, 8, 17);
        step(3);
        btn = 1'b1;
        step(14);
        vectors++;
        if (tq.size() != 0) begin
            errors++;
            $display("FAIL collision_ticks: %0d ticks outstanding, required 0", tq.size());
        end
        tick_en = 1'b0;
        tq.delete();
    endtask

    task automatic test_reset_mid;
        int r;
        btn = 1'b0;
        step(4);
        rst = 1'b1;
        #1;
        vectors++;
        if ({tick, press, rate, btn_level} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_wait: got tick=%b press=%b rate=%0d level=%b, required all 0",
                     tick, press, rate, btn_level);
        end
        step(2);
        rst = 1'b0;
        r = cyc;
        pq.push_back(r + 7);
        step(7);
        vectors++;
        if (rate !== 2'd1 || btn_level !== 1'b1) begin
            errors++;
            $display("FAIL midreset_repress1: got rate=%0d level=%b, required 1/1",
                     rate, btn_level);
        end
        btn = 1'b1;
        step(10);
        btn = 1'b0;
        pq.push_back(cyc + 7);
        step(7);
        vectors++;
        if (rate !== 2'd2) begin
            errors++;
            $display("FAIL midreset_rate2: got rate=%0d, required 2", rate);
        end
        step(2);
        rst = 1'b1;
        #1;
        vectors++;
        if ({tick, press, rate, btn_level} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_pressed: got tick=%b press=%b rate=%0d level=%b, required all 0",
                     tick, press, rate, btn_level);
        end
        step(3);
        rst = 1'b0;
        r = cyc;
        pq.push_back(r + 7);
        step(7);
        vectors++;
        if (rate !== 2'd1 || press !== 1'b1) begin
            errors++;
            $display("FAIL midreset_repress2: got rate=%0d press=%b, required 1/1",
                     rate, press);
        end
        btn = 1'b1;
        step(10);
        vectors++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL press_outstanding: %0d presses outstanding, required 0", pq.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        btn = 1'b1;
        #2;
        rst = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
